// File: rtl/program_sequencer_pkg.sv
// Shared constants for the stack-CPU program sequencer: sizes, opcode values,
// FSM state encoding and the decoded-opcode payload.
package program_sequencer_pkg;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned PTR_W  = ADDR_W + 1;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned LEN_W  = 2;

  localparam logic [NIB_W-1:0] OP_NOOP    = 4'h0;
  localparam logic [NIB_W-1:0] OP_PUSH    = 4'h1;
  localparam logic [NIB_W-1:0] OP_POP     = 4'h2;
  localparam logic [NIB_W-1:0] OP_OUTL    = 4'h3;
  localparam logic [NIB_W-1:0] OP_OUTH    = 4'h4;
  localparam logic [NIB_W-1:0] OP_SWAP    = 4'h5;
  localparam logic [NIB_W-1:0] OP_PUSF    = 4'h6;
  localparam logic [NIB_W-1:0] OP_ILLEGAL = 4'h7;
  localparam logic [NIB_W-1:0] OP_AND     = 4'h8;
  localparam logic [NIB_W-1:0] OP_OR      = 4'h9;
  localparam logic [NIB_W-1:0] OP_ADD     = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CRST = 3'd1,
    ST_OP   = 3'd2,
    ST_EXEC = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             has_operand;
    logic             illegal;
  } op_info_t;

endpackage

// File: rtl/program_sequencer_op_len_decoder.sv
// Combinational opcode decoder: execution slot length, operand presence and
// the illegal (CPU-hanging) opcode flag.
module program_sequencer_op_len_decoder
  import program_sequencer_pkg::*;
(
  input  logic [NIB_W-1:0] i_opcode,
  output op_info_t         o_info_c
);

  always_comb begin
    o_info_c = '{len: LEN_W'(1), has_operand: 1'b0, illegal: 1'b0};
    case (i_opcode)
      OP_PUSH, OP_PUSF: begin
        o_info_c.len         = LEN_W'(2);
        o_info_c.has_operand = 1'b1;
      end
      OP_POP, OP_SWAP, OP_AND, OP_OR, OP_ADD: begin
        o_info_c.len = LEN_W'(2);
      end
      OP_ILLEGAL: begin
        o_info_c.illegal = 1'b1;
      end
      OP_NOOP, OP_OUTL, OP_OUTH: begin
        o_info_c.len = LEN_W'(1);
      end
      default: begin
        o_info_c.len = LEN_W'(1);
      end
    endcase
  end

endmodule

// File: rtl/program_sequencer.sv
// Replays a loaded nibble program onto the stack CPU reset/inbits pins with
// per-opcode slot timing. Define PROGRAM_SEQUENCER_LOOP_EN to replay forever.
module program_sequencer
  import program_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load_valid,
  input  logic [NIB_W-1:0]  i_load_nibble,
  input  logic              i_clear,
  input  logic              i_run,
  output logic              o_cpu_rst,
  output logic [NIB_W-1:0]  o_cpu_inbits,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic              o_full,
  output logic [ADDR_W-1:0] o_pc
);

  seq_state_t        r_state, w_state_next;
  logic [PTR_W-1:0]  r_wr_ptr, w_wr_ptr_next;
  logic [ADDR_W-1:0] r_pc, w_pc_next;
  logic [LEN_W-1:0]  r_slot, w_slot_next;
  logic [NIB_W-1:0]  r_mem [DEPTH];

  logic              r_cpu_rst, w_cpu_rst_next;
  logic [NIB_W-1:0]  r_cpu_inbits, w_cpu_inbits_next;
  logic              r_busy, w_busy_next;
  logic              r_done, w_done_next;
  logic              r_err, w_err_next;
  logic              r_full, w_full_next;

  logic [NIB_W-1:0]  w_opcode;
  logic [NIB_W-1:0]  w_operand;
  op_info_t          w_info;
  logic [PTR_W-1:0]  w_pc_inc1;
  logic [PTR_W-1:0]  w_pc_adv;
  logic              w_load_ok;
  logic              w_is_full;
  logic              w_wr_en;

  assign w_opcode  = r_mem[r_pc];
  assign w_operand = r_mem[r_pc + ADDR_W'(1)];
  assign w_pc_inc1 = PTR_W'(r_pc) + PTR_W'(1);
  assign w_pc_adv  = PTR_W'(r_pc) + (w_info.has_operand ? PTR_W'(2) : PTR_W'(1));
  assign w_load_ok = (r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR);
  assign w_is_full = (r_wr_ptr == PTR_W'(DEPTH));
  assign w_wr_en   = w_load_ok && !i_clear && i_load_valid && !w_is_full;

  program_sequencer_op_len_decoder u_op_len_decoder (
    .i_opcode (w_opcode),
    .o_info_c (w_info)
  );

  // Write pointer: clear wins over load; saturates at DEPTH.
  always_comb begin
    w_wr_ptr_next = r_wr_ptr;
    if (w_load_ok) begin
      if (i_clear) begin
        w_wr_ptr_next = '0;
      end else if (i_load_valid && !w_is_full) begin
        w_wr_ptr_next = r_wr_ptr + PTR_W'(1);
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_slot_next  = r_slot;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_run && (r_wr_ptr != '0)) begin
          w_state_next = ST_CRST;
          w_pc_next    = '0;
        end
      end
      ST_CRST: begin
        w_state_next = ST_OP;
      end
      ST_OP: begin
        if (w_info.illegal) begin
          w_state_next = ST_ERR;
        end else if (w_info.has_operand && (w_pc_inc1 >= r_wr_ptr)) begin
          w_state_next = ST_ERR;
        end else begin
          w_state_next = ST_EXEC;
          w_slot_next  = LEN_W'(w_info.len - LEN_W'(1));
        end
      end
      ST_EXEC: begin
        if (r_slot != '0) begin
          w_slot_next = LEN_W'(r_slot - LEN_W'(1));
        end else if (w_pc_adv >= r_wr_ptr) begin
`ifdef PROGRAM_SEQUENCER_LOOP_EN
          w_state_next = ST_OP;
          w_pc_next    = '0;
`else
          w_state_next = ST_DONE;
          w_pc_next    = ADDR_W'(w_pc_adv);
`endif
        end else begin
          w_state_next = ST_OP;
          w_pc_next    = ADDR_W'(w_pc_adv);
        end
      end
      ST_ERR: begin
        w_state_next = ST_ERR;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered, so outputs come straight from flops
  always_comb begin
    w_cpu_rst_next    = (w_state_next == ST_CRST);
    w_busy_next       = (w_state_next == ST_CRST) || (w_state_next == ST_OP) ||
                        (w_state_next == ST_EXEC);
    w_done_next       = (w_state_next == ST_DONE);
    w_err_next        = (w_state_next == ST_ERR);
    w_full_next       = (w_wr_ptr_next == PTR_W'(DEPTH));
    w_cpu_inbits_next = '0;
    case (w_state_next)
      ST_OP: begin
        w_cpu_inbits_next = r_mem[w_pc_next];
      end
      ST_EXEC: begin
        if (r_state == ST_OP) begin
          w_cpu_inbits_next = w_info.has_operand ? w_operand : '0;
        end else begin
          w_cpu_inbits_next = r_cpu_inbits;
        end
      end
      default: begin
        w_cpu_inbits_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= '0;
      r_pc         <= '0;
      r_slot       <= '0;
      r_cpu_rst    <= 1'b0;
      r_cpu_inbits <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_full       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_ptr     <= w_wr_ptr_next;
      r_pc         <= w_pc_next;
      r_slot       <= w_slot_next;
      r_cpu_rst    <= w_cpu_rst_next;
      r_cpu_inbits <= w_cpu_inbits_next;
      r_busy       <= w_busy_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_full       <= w_full_next;
    end
  end

  // Program memory is not reset; reset only makes it unreachable via wr_ptr.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_load_nibble;
    end
  end

  assign o_cpu_rst    = r_cpu_rst;
  assign o_cpu_inbits = r_cpu_inbits;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_full       = r_full;
  assign o_pc         = r_pc;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer (default build, looping disabled):
// directed programs plus random programs checked against a trace model.
module tb_program_sequencer;
  import program_sequencer_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_valid;
  logic [3:0]        load_nibble;
  logic              clear;
  logic              run;
  logic              cpu_rst;
  logic [3:0]        cpu_inbits;
  logic              busy;
  logic              done;
  logic              err;
  logic              full;
  logic [ADDR_W-1:0] pc;

  int checks = 0;
  int errors = 0;

  program_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .i_load_valid  (load_valid),
    .i_load_nibble (load_nibble),
    .i_clear       (clear),
    .i_run         (run),
    .o_cpu_rst     (cpu_rst),
    .o_cpu_inbits  (cpu_inbits),
    .o_busy        (busy),
    .o_done        (done),
    .o_err         (err),
    .o_full        (full),
    .o_pc          (pc)
  );

  always #5 clk = ~clk;

  // Reference model state: program image and expected per-cycle pin trace
  logic [3:0] prog [16];
  int         prog_n;
  logic [4:0] exp_q [$];   // {cpu_rst, inbits}
  bit         exp_err;
  int         exp_pc;

  function automatic void build_model();
    int p;
    logic [3:0] op;
    exp_q.delete();
    exp_err = 1'b0;
    p = 0;
    exp_q.push_back({1'b1, 4'h0});
    while (1) begin
      op = prog[p];
      exp_q.push_back({1'b0, op});
      if (op == 4'h7) begin
        exp_err = 1'b1;
        break;
      end
      if (op == 4'h1 || op == 4'h6) begin
        if (p + 1 >= prog_n) begin
          exp_err = 1'b1;
          break;
        end
        exp_q.push_back({1'b0, prog[p+1]});
        exp_q.push_back({1'b0, prog[p+1]});
        p = p + 2;
      end else if (op == 4'h2 || op == 4'h5 || op == 4'h8 || op == 4'h9 || op == 4'hA) begin
        exp_q.push_back(5'h00);
        exp_q.push_back(5'h00);
        p = p + 1;
      end else begin
        exp_q.push_back(5'h00);
        p = p + 1;
      end
      if (p >= prog_n) break;
    end
    exp_pc = p % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_prog();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < prog_n; i++) begin
      load_valid  = 1'b1;
      load_nibble = prog[i];
      tick();
    end
    load_valid = 1'b0;
  endtask

  // Starts a run and compares every busy cycle and the final status against the model.
  task automatic run_and_check(input string tag, input bit noise);
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if ({cpu_rst, cpu_inbits, busy} !== {exp_q[i], 1'b1}) begin
        errors++;
        $display("FAIL %s cycle %0d: rst/inbits/busy got %b/%h/%b want %b/%h/1",
                 tag, i, cpu_rst, cpu_inbits, busy, exp_q[i][4], exp_q[i][3:0]);
      end
      if (noise) begin
        load_valid  = 1'($urandom_range(0, 1));
        load_nibble = 4'($urandom);
        clear       = 1'($urandom_range(0, 1));
        run         = 1'($urandom_range(0, 1));
      end
      tick();
    end
    load_valid = 1'b0;
    clear      = 1'b0;
    run        = 1'b0;
    checks++;
    if ({busy, done, err, cpu_rst, cpu_inbits} !== {1'b0, !exp_err, exp_err, 1'b0, 4'h0} ||
        pc !== ADDR_W'(exp_pc)) begin
      errors++;
      $display("FAIL %s end: busy/done/err/rst/inbits/pc got %b/%b/%b/%b/%h/%0d want 0/%b/%b/0/0/%0d",
               tag, busy, done, err, cpu_rst, cpu_inbits, pc, !exp_err, exp_err, exp_pc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({cpu_rst, cpu_inbits, busy, done, err, full, pc} !== '0) begin
      errors++;
      $display("FAIL reset: rst/inbits/busy/done/err/full/pc got %b/%h/%b/%b/%b/%b/%0d want all 0",
               cpu_rst, cpu_inbits, busy, done, err, full, pc);
    end
  endtask

  task automatic test_program1();
    logic [3:0] want [12];
    want = '{4'h0, 4'h1, 4'h3, 4'h3, 4'h1, 4'h4, 4'h4, 4'hA, 4'h0, 4'h0, 4'h3, 4'h0};
    prog[0] = 4'h1; prog[1] = 4'h3; prog[2] = 4'h1;
    prog[3] = 4'h4; prog[4] = 4'hA; prog[5] = 4'h3;
    prog_n = 6;
    load_prog();
    run = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (cpu_inbits !== want[i] || busy !== 1'b1 || cpu_rst !== (i == 0)) begin
        errors++;
        $display("FAIL prog1 cycle %0d: inbits/busy/rst got %h/%b/%b want %h/1/%b",
                 i, cpu_inbits, busy, cpu_rst, want[i], (i == 0));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || pc !== ADDR_W'(6)) begin
      errors++;
      $display("FAIL prog1 end: done/busy/pc got %b/%b/%0d want 1/0/6", done, busy, pc);
    end
  endtask

  task automatic test_illegal();
    prog[0] = 4'h1; prog[1] = 4'h2; prog[2] = 4'h7; prog[3] = 4'h3;
    prog_n = 4;
    load_prog();
    build_model();
    run_and_check("illegal", 1'b0);
    checks++;
    if (err !== 1'b1 || pc !== ADDR_W'(2)) begin
      errors++;
      $display("FAIL illegal status: err/pc got %b/%0d want 1/2", err, pc);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0 || cpu_inbits !== 4'h0) begin
      errors++;
      $display("FAIL illegal run-ignored: err/busy/rst/inbits got %b/%b/%b/%h want 1/0/0/0",
               err, busy, cpu_rst, cpu_inbits);
    end
    do_reset();
  endtask

  task automatic test_truncated();
    prog[0] = 4'h2; prog[1] = 4'h1;
    prog_n = 2;
    load_prog();
    build_model();
    run_and_check("truncated", 1'b0);
    checks++;
    if (err !== 1'b1 || pc !== ADDR_W'(1)) begin
      errors++;
      $display("FAIL truncated status: err/pc got %b/%0d want 1/1", err, pc);
    end
    do_reset();
  endtask

  task automatic test_full();
    logic [3:0] one_slot [8];
    one_slot = '{4'h0, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 17; i++) begin
      load_valid  = 1'b1;
      load_nibble = (i < 16) ? one_slot[$urandom_range(0, 7)] : 4'h7;
      if (i < 16) prog[i] = load_nibble;
      tick();
      checks++;
      if (full !== (i >= 15)) begin
        errors++;
        $display("FAIL full after load %0d: got %b want %b", i + 1, full, (i >= 15));
      end
    end
    load_valid = 1'b0;
    prog_n = 16;
    build_model();
    run_and_check("full", 1'b0);
  endtask

  task automatic test_rst_mid_run();
    prog[0] = 4'h1; prog[1] = 4'h3; prog[2] = 4'h1;
    prog[3] = 4'h4; prog[4] = 4'hA; prog[5] = 4'h3;
    prog_n = 6;
    load_prog();
    run = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, err, full, cpu_rst, cpu_inbits} !== '0) begin
      errors++;
      $display("FAIL rst-mid-run: busy/done/err/full/rst/inbits got %b/%b/%b/%b/%b/%h want all 0",
               busy, done, err, full, cpu_rst, cpu_inbits);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    checks++;
    if (busy !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL rst-mid-run empty run: busy/rst got %b/%b want 0/0", busy, cpu_rst);
    end
  endtask

  // Random programs with ignored-input noise during replay, then a repeat run from DONE.
  task automatic test_random_back_to_back();
    for (int t = 0; t < 25; t++) begin
      prog_n = $urandom_range(1, 16);
      for (int i = 0; i < prog_n; i++) begin
        prog[i] = 4'($urandom);
        if (prog[i] == 4'h7 && $urandom_range(0, 3) != 0) prog[i] = 4'($urandom_range(8, 15));
      end
      load_prog();
      build_model();
      run_and_check("random", 1'b1);
      if (exp_err) begin
        do_reset();
      end else begin
        run_and_check("back_to_back", 1'b0);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    load_valid  = 1'b0;
    load_nibble = 4'h0;
    clear       = 1'b0;
    run         = 1'b0;
    test_reset();
    test_program1();
    test_illegal();
    test_truncated();
    test_full();
    test_rst_mid_run();
    test_random_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
